// File: rtl/mem_burst_ctrl_if.sv
// Bundled command, write-data, read-data and memory-side signals of the burst controller.
// The slave view belongs to the controller; the master view belongs to its environment.
interface mem_burst_ctrl_if #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 6,
  parameter int LEN_WIDTH  = 7
);
  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic                  cmd_wr_rd_i;
  logic [ADDR_WIDTH-1:0] cmd_addr_i;
  logic [LEN_WIDTH-1:0]  cmd_len_i;
  logic                  wd_valid_i;
  logic                  wd_ready_o;
  logic [WIDTH-1:0]      wd_data_i;
  logic                  rd_valid_o;
  logic                  rd_ready_i;
  logic [WIDTH-1:0]      rd_data_o;
  logic                  mem_valid_o;
  logic                  mem_wr_rd_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [WIDTH-1:0]      mem_wdata_o;
  logic [WIDTH-1:0]      mem_rdata_i;
  logic                  mem_ready_i;
  logic                  busy_o;
  logic                  done_o;

  modport slave (
    input  cmd_valid_i, cmd_wr_rd_i, cmd_addr_i, cmd_len_i,
    input  wd_valid_i, wd_data_i, rd_ready_i, mem_rdata_i, mem_ready_i,
    output cmd_ready_o, wd_ready_o, rd_valid_o, rd_data_o,
    output mem_valid_o, mem_wr_rd_o, mem_addr_o, mem_wdata_o, busy_o, done_o
  );

  modport master (
    output cmd_valid_i, cmd_wr_rd_i, cmd_addr_i, cmd_len_i,
    output wd_valid_i, wd_data_i, rd_ready_i, mem_rdata_i, mem_ready_i,
    input  cmd_ready_o, wd_ready_o, rd_valid_o, rd_data_o,
    input  mem_valid_o, mem_wr_rd_o, mem_addr_o, mem_wdata_o, busy_o, done_o
  );
endinterface

// File: rtl/mem_burst_ctrl.sv
// Burst master for a single-port memory: one beat per cycle with wrapping addresses,
// write data from a stream, read data returned through a credit-limited FIFO.
module mem_burst_ctrl #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  mem_burst_ctrl_if.slave  bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;

  logic [ADDR_WIDTH-1:0] addr_r;
  logic [ADDR_WIDTH-1:0] addr_nxt_s;
  logic [LEN_WIDTH-1:0]  beats_left_r;
  logic                  dir_wr_r;
  logic [CNT_W-1:0]      inflight_r;
  logic                  done_r;

  logic                  mem_valid_r;
  logic                  mem_wr_rd_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic [WIDTH-1:0]      mem_wdata_r;

  logic [WIDTH-1:0]      fifo_mem_r [FIFO_DEPTH];
  logic [CNT_W-1:0]      wr_ptr_r;
  logic [CNT_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      fifo_count_s;

  logic                  cmd_ready_s;
  logic                  cmd_accept_s;
  logic                  wd_ready_s;
  logic                  issue_s;
  logic                  busy_s;
  logic                  credit_ok_s;
  logic                  ret_s;
  logic                  last_ret_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  rd_valid_s;
  logic                  done_s;

  assign fifo_count_s = wr_ptr_r - rd_ptr_r;
  assign rd_valid_s   = (fifo_count_s != {CNT_W{1'b0}});
  assign pop_s        = rd_valid_s && bus.rd_ready_i;
  // Credit uses registered occupancy only, so a same-cycle pop never opens a slot early.
  assign credit_ok_s  = ({1'b0, fifo_count_s} + {1'b0, inflight_r}) < (CNT_W + 1)'(FIFO_DEPTH);
  // A response only counts when a beat is outstanding; stale handshakes after reset are dropped.
  assign ret_s        = bus.mem_ready_i && (inflight_r != {CNT_W{1'b0}});
  assign last_ret_s   = ret_s && (inflight_r == CNT_W'(1));
  assign push_s       = ret_s && !dir_wr_r;
  assign cmd_accept_s = bus.cmd_valid_i && cmd_ready_s;
  assign addr_nxt_s   = (addr_r == ADDR_WIDTH'(DEPTH - 1)) ? {ADDR_WIDTH{1'b0}}
                                                          : addr_r + ADDR_WIDTH'(1);
  assign done_s       = (cmd_accept_s && (bus.cmd_len_i == {LEN_WIDTH{1'b0}})) ||
                        ((state_r == ST_DRAIN) && last_ret_s);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_accept_s && (bus.cmd_len_i != {LEN_WIDTH{1'b0}})) begin
          state_nxt_s = bus.cmd_wr_rd_i ? ST_WRITE : ST_READ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WRITE, ST_READ: begin
        if (issue_s && (beats_left_r == LEN_WIDTH'(1))) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_DRAIN: begin
        if (last_ret_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output and beat-issue decode
  always_comb begin
    cmd_ready_s = 1'b0;
    wd_ready_s  = 1'b0;
    issue_s     = 1'b0;
    busy_s      = 1'b1;
    case (state_r)
      ST_IDLE: begin
        cmd_ready_s = 1'b1;
        busy_s      = 1'b0;
      end
      ST_WRITE: begin
        wd_ready_s = (beats_left_r != {LEN_WIDTH{1'b0}});
        issue_s    = wd_ready_s && bus.wd_valid_i;
      end
      ST_READ: begin
        issue_s = (beats_left_r != {LEN_WIDTH{1'b0}}) && credit_ok_s;
      end
      ST_DRAIN: begin
        busy_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // Burst bookkeeping and registered memory-side beat
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_r       <= {ADDR_WIDTH{1'b0}};
      beats_left_r <= {LEN_WIDTH{1'b0}};
      dir_wr_r     <= 1'b0;
      inflight_r   <= {CNT_W{1'b0}};
      done_r       <= 1'b0;
      mem_valid_r  <= 1'b0;
      mem_wr_rd_r  <= 1'b0;
      mem_addr_r   <= {ADDR_WIDTH{1'b0}};
      mem_wdata_r  <= {WIDTH{1'b0}};
    end else begin
      done_r      <= done_s;
      mem_valid_r <= issue_s;
      if (cmd_accept_s) begin
        addr_r       <= bus.cmd_addr_i;
        beats_left_r <= bus.cmd_len_i;
        dir_wr_r     <= bus.cmd_wr_rd_i;
      end else if (issue_s) begin
        addr_r       <= addr_nxt_s;
        beats_left_r <= beats_left_r - LEN_WIDTH'(1);
      end
      if (issue_s) begin
        mem_wr_rd_r <= dir_wr_r;
        mem_addr_r  <= addr_r;
        if (dir_wr_r) begin
          mem_wdata_r <= bus.wd_data_i;
        end
      end
      case ({issue_s, ret_s})
        2'b10:   inflight_r <= inflight_r + CNT_W'(1);
        2'b01:   inflight_r <= inflight_r - CNT_W'(1);
        default: inflight_r <= inflight_r;
      endcase
    end
  end

  // Read-return FIFO
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_r <= {CNT_W{1'b0}};
      rd_ptr_r <= {CNT_W{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r[PTR_W-1:0]] <= bus.mem_rdata_i;
        wr_ptr_r                        <= wr_ptr_r + CNT_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + CNT_W'(1);
      end
    end
  end

  assign bus.cmd_ready_o = cmd_ready_s;
  assign bus.wd_ready_o  = wd_ready_s;
  assign bus.rd_valid_o  = rd_valid_s;
  assign bus.rd_data_o   = fifo_mem_r[rd_ptr_r[PTR_W-1:0]];
  assign bus.mem_valid_o = mem_valid_r;
  assign bus.mem_wr_rd_o = mem_wr_rd_r;
  assign bus.mem_addr_o  = mem_addr_r;
  assign bus.mem_wdata_o = mem_wdata_r;
  assign bus.busy_o      = busy_s;
  assign bus.done_o      = done_r;

endmodule
